aes_start_gen: RTL and testbench

- Generates the aes_start strobe that launches one AES operation and tracks that operation to completion.
- Sits between the HPS command bridge and the AES core, on acq_clk, so the acquisition-side start trigger sees a clean, fixed-width start level.
- Holds aes_start high for START_WIDTH consecutive cycles, then waits for aes_done.
- Reports completion, timeout and a run count back to the HPS.

---
 rtl/aes_ctrl_pkg.sv | 16 +
 rtl/aes_start_gen_if.sv | 40 ++++
 rtl/aes_start_gen.sv | 104 ++++++++++
 tb/tb_aes_start_gen.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/aes_ctrl_pkg.sv
// Shared AES control types and defaults: FSM state encoding plus the start-width/timeout
// defaults also used by the start-trigger config and the HPS register map.
package aes_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } aes_state_e;

  localparam int AES_START_WIDTH_DEF = 4;
  localparam int AES_TIMEOUT_DEF     = 1024;
  localparam int AES_RUN_CNT_W_DEF   = 16;

endpackage

// File: rtl/aes_start_gen_if.sv
// Command/status bundle between the HPS bridge, the AES core and aes_start_gen.
// master = HPS/AES side, slave = the start generator.
interface aes_start_gen_if
  import aes_ctrl_pkg::*;
#(
  parameter int CNT_W = AES_RUN_CNT_W_DEF
);

  logic             cmd_go;
  logic             cmd_ready;
  logic             aes_done;
  logic             aes_start;
  logic             busy;
  logic             done_pulse;
  logic             timeout_err;
  logic [CNT_W-1:0] run_count;

  modport master (
    output cmd_go,
    output aes_done,
    input  cmd_ready,
    input  aes_start,
    input  busy,
    input  done_pulse,
    input  timeout_err,
    input  run_count
  );

  modport slave (
    input  cmd_go,
    input  aes_done,
    output cmd_ready,
    output aes_start,
    output busy,
    output done_pulse,
    output timeout_err,
    output run_count
  );

endinterface

// File: rtl/aes_start_gen.sv
// Fixed-width AES start strobe generator with done/timeout tracking and a run counter.
// Latency: aes_start rises one cycle after cmd_go; cmd_go is dropped whenever cmd_ready=0.
module aes_start_gen
  import aes_ctrl_pkg::*;
#(
  parameter int START_WIDTH = AES_START_WIDTH_DEF,
  parameter int TIMEOUT     = AES_TIMEOUT_DEF,
  parameter int CNT_W       = AES_RUN_CNT_W_DEF
) (
  input logic             acq_clk,
  input logic             reset_n,
  aes_start_gen_if.slave  bus
);

  // One shared counter: counts down the start width, then up through the wait window.
  localparam logic [15:0] WIDTH_LOAD   = 16'(START_WIDTH - 1);
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT - 1);

  aes_state_e       state_q, state_d;
  logic [15:0]      cnt_q, cnt_d;
  logic             terr_q, terr_d;
  logic [CNT_W-1:0] run_cnt_q, run_cnt_d;

  logic             start_q;
  logic             busy_q;
  logic             done_pulse_q;
  logic             ready_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    terr_d    = terr_q;
    run_cnt_d = run_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (bus.cmd_go) begin
          state_d = START;
          cnt_d   = WIDTH_LOAD;
          terr_d  = 1'b0;
        end
      end
      START: begin
        if (cnt_q == 16'd0) begin
          state_d = WAIT;
          cnt_d   = 16'd0;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      WAIT: begin
        // Done is checked first so a completion on the last window cycle is not an error.
        if (bus.aes_done) begin
          state_d   = DONE;
          cnt_d     = 16'd0;
          run_cnt_d = run_cnt_q + 1'b1;
        end else if (cnt_q == TIMEOUT_LAST) begin
          state_d = IDLE;
          cnt_d   = 16'd0;
          terr_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 16'd0;
      end
    endcase
  end

  // Outputs are decoded from the next state so every output comes straight off a flop.
  always_ff @(posedge acq_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      cnt_q        <= 16'd0;
      terr_q       <= 1'b0;
      run_cnt_q    <= '0;
      start_q      <= 1'b0;
      busy_q       <= 1'b0;
      done_pulse_q <= 1'b0;
      ready_q      <= 1'b1;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      terr_q       <= terr_d;
      run_cnt_q    <= run_cnt_d;
      start_q      <= (state_d == START);
      busy_q       <= (state_d == START) || (state_d == WAIT);
      done_pulse_q <= (state_d == DONE);
      ready_q      <= (state_d == IDLE);
    end
  end

  assign bus.aes_start   = start_q;
  assign bus.busy        = busy_q;
  assign bus.done_pulse  = done_pulse_q;
  assign bus.cmd_ready   = ready_q;
  assign bus.timeout_err = terr_q;
  assign bus.run_count   = run_cnt_q;

endmodule

// File: tb/tb_aes_start_gen.sv
// Directed bench for aes_start_gen: cycle tables for normal, timeout and back-to-back runs,
// plus hand sequences for reset-with-go, mid-run async reset and run_count wrap.
module tb_aes_start_gen;

  localparam int W  = 4;
  localparam int TO = 8;

  logic acq_clk = 1'b0;
  logic reset_n;

  always #5 acq_clk = ~acq_clk;

  aes_start_gen_if #(.CNT_W(16)) u_if ();
  aes_start_gen_if #(.CNT_W(2))  w_if ();

  aes_start_gen #(.START_WIDTH(W), .TIMEOUT(TO), .CNT_W(16)) dut (
    .acq_clk (acq_clk),
    .reset_n (reset_n),
    .bus     (u_if.slave)
  );

  // Narrow run counter so a wrap is reachable in a handful of runs.
  aes_start_gen #(.START_WIDTH(2), .TIMEOUT(TO), .CNT_W(2)) dut_w (
    .acq_clk (acq_clk),
    .reset_n (reset_n),
    .bus     (w_if.slave)
  );

  typedef struct {
    logic        go;
    logic        done;
    logic        st;
    logic        bz;
    logic        dp;
    logic        rdy;
    logic        er;
    logic [15:0] rc;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  function automatic void add(input int go, input int done, input int st, input int bz,
                              input int dp, input int rdy, input int er, input int rc);
    vec_t v;
    v.go   = go[0];
    v.done = done[0];
    v.st   = st[0];
    v.bz   = bz[0];
    v.dp   = dp[0];
    v.rdy  = rdy[0];
    v.er   = er[0];
    v.rc   = rc[15:0];
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input int idx, input logic [15:0] act,
                     input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic chk_main(input string tag, input int idx, input vec_t v);
    chk({tag, ".aes_start"},   idx, {15'd0, u_if.aes_start},   {15'd0, v.st});
    chk({tag, ".busy"},        idx, {15'd0, u_if.busy},        {15'd0, v.bz});
    chk({tag, ".done_pulse"},  idx, {15'd0, u_if.done_pulse},  {15'd0, v.dp});
    chk({tag, ".cmd_ready"},   idx, {15'd0, u_if.cmd_ready},   {15'd0, v.rdy});
    chk({tag, ".timeout_err"}, idx, {15'd0, u_if.timeout_err}, {15'd0, v.er});
    chk({tag, ".run_count"},   idx, u_if.run_count,            v.rc);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t rv;
    reset_n       = 1'b0;
    u_if.cmd_go   = 1'b1;
    u_if.aes_done = 1'b0;
    w_if.cmd_go   = 1'b0;
    w_if.aes_done = 1'b1;

    // Reset held with cmd_go high: all outputs must sit at reset values.
    repeat (3) @(negedge acq_clk);
    rv = '{go: 1'b0, done: 1'b0, st: 1'b0, bz: 1'b0, dp: 1'b0, rdy: 1'b1, er: 1'b0, rc: 16'd0};
    chk_main("reset", 0, rv);
    reset_n     = 1'b1;
    u_if.cmd_go = 1'b0;

    // Normal run; cmd_go repeated during START and during DONE must be dropped.
    add(0,0, 0,0,0,1,0,0);
    add(0,0, 0,0,0,1,0,0);
    add(1,0, 0,0,0,1,0,0);
    add(0,0, 1,1,0,0,0,0);
    add(1,0, 1,1,0,0,0,0);
    add(1,0, 1,1,0,0,0,0);
    add(0,0, 1,1,0,0,0,0);
    repeat (5) add(0,0, 0,1,0,0,0,0);
    add(0,1, 0,1,0,0,0,0);
    add(1,0, 0,0,1,0,0,1);
    add(0,0, 0,0,0,1,0,1);
    add(0,0, 0,0,0,1,0,1);
    // Timeout: aes_done during START is ignored, 8 WAIT cycles then sticky error.
    add(1,0, 0,0,0,1,0,1);
    add(0,1, 1,1,0,0,0,1);
    add(0,0, 1,1,0,0,0,1);
    add(0,0, 1,1,0,0,0,1);
    add(0,1, 1,1,0,0,0,1);
    repeat (8) add(0,0, 0,1,0,0,0,1);
    add(0,0, 0,0,0,1,1,1);
    add(0,0, 0,0,0,1,1,1);
    add(1,0, 0,0,0,1,1,1);
    add(0,0, 1,1,0,0,0,1);
    repeat (3) add(0,0, 1,1,0,0,0,1);
    // aes_done on the last WAIT cycle: done wins, no error.
    repeat (7) add(0,0, 0,1,0,0,0,1);
    add(0,1, 0,1,0,0,0,1);
    add(0,0, 0,0,1,0,0,2);
    add(0,0, 0,0,0,1,0,2);
    // Back-to-back with aes_done held high: one WAIT cycle, 3 low cycles between starts.
    add(1,1, 0,0,0,1,0,2);
    repeat (4) add(0,1, 1,1,0,0,0,2);
    add(0,1, 0,1,0,0,0,2);
    add(0,1, 0,0,1,0,0,3);
    add(1,1, 0,0,0,1,0,3);
    repeat (4) add(0,1, 1,1,0,0,0,3);
    add(0,1, 0,1,0,0,0,3);
    add(0,1, 0,0,1,0,0,4);
    add(0,0, 0,0,0,1,0,4);

    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge acq_clk);
      #1;
      u_if.cmd_go   = vecs[i].go;
      u_if.aes_done = vecs[i].done;
      @(negedge acq_clk);
      chk_main("table", i, vecs[i]);
    end

    // Async reset during the second aes_start cycle.
    @(posedge acq_clk);
    #1 u_if.cmd_go = 1'b1;
    @(posedge acq_clk);
    #1 u_if.cmd_go = 1'b0;
    @(posedge acq_clk);
    #2;
    chk("midrst.start_before", 0, {15'd0, u_if.aes_start}, 16'd1);
    reset_n = 1'b0;
    #1;
    rv = '{go: 1'b0, done: 1'b0, st: 1'b0, bz: 1'b0, dp: 1'b0, rdy: 1'b1, er: 1'b0, rc: 16'd0};
    chk_main("midrst", 0, rv);
    @(negedge acq_clk);
    reset_n = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      @(negedge acq_clk);
      chk_main("postrst", i, rv);
    end

    // run_count wrap on the 2-bit instance.
    for (int r = 1; r <= 4; r++) begin
      bit seen;
      seen = 1'b0;
      @(posedge acq_clk);
      #1 w_if.cmd_go = 1'b1;
      @(posedge acq_clk);
      #1 w_if.cmd_go = 1'b0;
      for (int c = 0; c < 20 && !seen; c++) begin
        @(negedge acq_clk);
        if (w_if.done_pulse === 1'b1) seen = 1'b1;
      end
      chk("wrap.done_seen", r, {15'd0, seen}, 16'd1);
      chk("wrap.run_count", r, {14'd0, w_if.run_count}, 16'(r % 4));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
